// File: rtl/program_codec_pkg.sv
// program_codec_pkg: shared program block codec types and format constants
package program_codec_pkg;
    localparam int PROG_BLOCK_HDR_BYTES = 4;
    typedef enum logic [2:0] {
        IDLE, HDR_LEN, HDR_ADDR_HI, HDR_ADDR_LO, HDR_TYPE, DATA
    } program_encoder_state;
    typedef enum logic [2:0] {
        DEC_LEN, DEC_ADDR_HI, DEC_ADDR_LO, DEC_TYPE, DEC_DATA
    } program_decoder_state;
endpackage

// File: rtl/program_encoder.sv
// program_encoder: serialises one program block into a length/addr/type/data byte stream with write addresses
//   clk, rst_n (async active-low)                          clock and reset
//   start, ready, done, len_err                            block request / status
//   block_length, block_address, block_type, block_data    block to encode (byte i at bits [8*i+:8])
//   out_data, out_valid, out_ready                         valid/ready byte stream
//   prog_addr, prog_overflow                               running write address and sticky wrap flag
module program_encoder
    import program_codec_pkg::*;
#(
    parameter int PROGRAM_SIZE        = 1,
    // kept at least one bit wide so a single-byte program still has a legal address port
    parameter int PROG_ADDR_BITS      = (PROGRAM_SIZE > 1) ? $clog2(PROGRAM_SIZE) : 1,
    parameter int DATA_BLOCK_MAX_SIZE = 64,
    parameter int DATA_BLOCK_CNT_BITS = $clog2(DATA_BLOCK_MAX_SIZE + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic                             ready,
    output logic                             done,
    output logic                             len_err,
    input  logic [7:0]                       block_length,
    input  logic [15:0]                      block_address,
    input  logic [7:0]                       block_type,
    input  logic [8*DATA_BLOCK_MAX_SIZE-1:0] block_data,
    output logic [7:0]                       out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [PROG_ADDR_BITS-1:0]        prog_addr,
    output logic                             prog_overflow
);
    program_encoder_state state, state_nxt;
    logic [DATA_BLOCK_CNT_BITS-1:0] len_q, cnt;
    logic [15:0] addr_q;
    logic [7:0] type_q;
    logic [8*DATA_BLOCK_MAX_SIZE-1:0] data_q;
    logic accept, fire, oversize, last_data;
    assign accept    = ready & start;
    assign out_valid = state != IDLE;
    assign fire      = out_valid & out_ready;
    assign oversize  = block_length > 8'(DATA_BLOCK_MAX_SIZE);
    assign last_data = (cnt + 1'b1) == len_q;
    always_comb begin
        state_nxt = state;
        out_data  = 8'h00;
        case (state)
            IDLE:        state_nxt = accept ? HDR_LEN : IDLE;
            HDR_LEN: begin
                out_data  = 8'(len_q);
                state_nxt = out_ready ? HDR_ADDR_HI : state;
            end
            HDR_ADDR_HI: begin
                out_data  = addr_q[15:8];
                state_nxt = out_ready ? HDR_ADDR_LO : state;
            end
            HDR_ADDR_LO: begin
                out_data  = addr_q[7:0];
                state_nxt = out_ready ? HDR_TYPE : state;
            end
            HDR_TYPE: begin
                out_data  = type_q;
                state_nxt = !out_ready ? state : (len_q == '0) ? IDLE : DATA;
            end
            DATA: begin
                out_data  = data_q[8*cnt +: 8];
                state_nxt = (out_ready && last_data) ? IDLE : state;
            end
            default:     state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready         <= 1'b0;
            done          <= 1'b0;
            len_err       <= 1'b0;
            len_q         <= '0;
            addr_q        <= '0;
            type_q        <= '0;
            data_q        <= '0;
            cnt           <= '0;
            prog_addr     <= '0;
            prog_overflow <= 1'b0;
        end else begin
            ready <= state_nxt == IDLE;
            if (accept) begin
                done    <= 1'b0;
                len_err <= oversize;
                len_q   <= oversize ? DATA_BLOCK_CNT_BITS'(DATA_BLOCK_MAX_SIZE) : DATA_BLOCK_CNT_BITS'(block_length);
                addr_q  <= block_address;
                type_q  <= block_type;
                data_q  <= block_data;
                cnt     <= '0;
            end
            if (fire) begin
                prog_addr <= prog_addr + 1'b1;
                if (&prog_addr) prog_overflow <= 1'b1;
            end
            if (fire && state == DATA) cnt <= cnt + 1'b1;
            if (fire && state_nxt == IDLE) done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_program_encoder.sv
// tb_program_encoder: randomized self-checking bench for program_encoder against a byte-queue reference model
module tb_program_encoder;
    import program_codec_pkg::*;
    localparam int DMAX = 64;
    localparam int SZ   = 1024;
    localparam int SZ8  = 8;
    logic clk = 1'b0;
    logic rst_n, start, out_ready;
    logic [7:0] block_length, block_type;
    logic [15:0] block_address;
    logic [8*DMAX-1:0] block_data;
    logic ready, done, len_err, out_valid, prog_overflow;
    logic [7:0] out_data;
    logic [9:0] prog_addr;
    logic ready8, done8, len_err8, out_valid8, ovf8;
    logic [7:0] out_data8;
    logic [2:0] prog_addr8;
    int checks = 0, errors = 0;
    int exp_addr, exp_addr8;
    bit exp_ovf, exp_ovf8;
    logic [7:0] dat [DMAX];
    logic [7:0] ram [SZ];

    always #5 clk = ~clk;

    program_encoder #(.PROGRAM_SIZE(SZ), .DATA_BLOCK_MAX_SIZE(DMAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .done(done), .len_err(len_err),
        .block_length(block_length), .block_address(block_address), .block_type(block_type),
        .block_data(block_data), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .prog_addr(prog_addr), .prog_overflow(prog_overflow));

    program_encoder #(.PROGRAM_SIZE(SZ8), .DATA_BLOCK_MAX_SIZE(DMAX)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready8), .done(done8), .len_err(len_err8),
        .block_length(block_length), .block_address(block_address), .block_type(block_type),
        .block_data(block_data), .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready),
        .prog_addr(prog_addr8), .prog_overflow(ovf8));

    task automatic fill_random();
        for (int i = 0; i < DMAX; i++) dat[i] = 8'($urandom);
    endtask

    task automatic run_block(input logic [7:0] len, input logic [15:0] addr, input logic [7:0] typ, input int stall_pct);
        logic [7:0] exp_q [$];
        logic [7:0] held_d, want;
        bit stalled;
        int n, cycles;
        n = (len > DMAX) ? DMAX : int'(len);
        exp_q = {8'(n), addr[15:8], addr[7:0], typ};
        for (int i = 0; i < n; i++) exp_q.push_back(dat[i]);
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL ready_before_start: got %b expected 1", ready); end
        block_length = len; block_address = addr; block_type = typ;
        for (int i = 0; i < DMAX; i++) block_data[8*i +: 8] = dat[i];
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        block_length = 8'($urandom); block_address = 16'($urandom); block_type = 8'($urandom);
        block_data = {16{$urandom}};
        stalled = 0; cycles = 0;
        while (exp_q.size() > 0 && cycles < 2000) begin
            out_ready = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL stream_valid: got valid=%b done=%b expected valid=1 done=0", out_valid, done);
            end
            if (stalled) begin
                checks++;
                if (out_data !== held_d) begin errors++; $display("FAIL stall_hold: got %h expected %h", out_data, held_d); end
            end
            if (out_ready) begin
                want = exp_q.pop_front();
                checks++;
                if (out_data !== want || out_data8 !== want) begin
                    errors++; $display("FAIL byte: got %h/%h expected %h", out_data, out_data8, want);
                end
                checks++;
                if (prog_addr !== 10'(exp_addr) || prog_addr8 !== 3'(exp_addr8)) begin
                    errors++; $display("FAIL prog_addr: got %0d/%0d expected %0d/%0d", prog_addr, prog_addr8, exp_addr, exp_addr8);
                end
                ram[exp_addr] = out_data;
                if (exp_addr == SZ - 1) exp_ovf = 1;
                if (exp_addr8 == SZ8 - 1) exp_ovf8 = 1;
                exp_addr = (exp_addr + 1) % SZ;
                exp_addr8 = (exp_addr8 + 1) % SZ8;
                stalled = 0;
            end else begin
                stalled = 1; held_d = out_data;
            end
            @(posedge clk); #1;
            cycles++;
        end
        if (cycles >= 2000) begin errors++; $display("FAIL timeout: got %0d cycles expected < 2000", cycles); end
        out_ready = 1'($urandom);
        checks++;
        if (done !== 1'b1 || ready !== 1'b1 || out_valid !== 1'b0 || done8 !== 1'b1 || ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            errors++; $display("FAIL block_end: got done=%b ready=%b valid=%b expected 1 1 0", done, ready, out_valid);
        end
        checks++;
        if (len_err !== (len > DMAX) || len_err8 !== (len > DMAX)) begin
            errors++; $display("FAIL len_err: got %b expected %b", len_err, (len > DMAX));
        end
        checks++;
        if (prog_addr !== 10'(exp_addr) || prog_overflow !== exp_ovf || prog_addr8 !== 3'(exp_addr8) || ovf8 !== exp_ovf8) begin
            errors++; $display("FAIL end_addr: got %0d ovf=%b / %0d ovf=%b expected %0d %b / %0d %b",
                prog_addr, prog_overflow, prog_addr8, ovf8, exp_addr, exp_ovf, exp_addr8, exp_ovf8);
        end
        if (stall_pct == 0) begin
            checks++;
            if (cycles != n + PROG_BLOCK_HDR_BYTES) begin
                errors++; $display("FAIL throughput: got %0d cycles expected %0d", cycles, n + PROG_BLOCK_HDR_BYTES);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        block_length = '0; block_address = '0; block_type = '0; block_data = '0;
        repeat (2) @(posedge clk); #1;
        checks++;
        if (ready !== 0 || done !== 0 || len_err !== 0 || out_valid !== 0 || out_data !== 8'h00 ||
            prog_addr !== 10'd0 || prog_overflow !== 0) begin
            errors++; $display("FAIL reset_values: got r=%b d=%b e=%b v=%b data=%h a=%0d o=%b expected all zero",
                ready, done, len_err, out_valid, out_data, prog_addr, prog_overflow);
        end
        rst_n = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got ready=%b valid=%b expected 1 0", ready, out_valid);
        end
        exp_addr = 0; exp_addr8 = 0; exp_ovf = 0; exp_ovf8 = 0;
    endtask

    task automatic test_basic();
        fill_random();
        dat[0] = 8'hAA; dat[1] = 8'h55;
        run_block(8'd2, 16'h1234, 8'h00, 0);
    endtask

    task automatic test_zero_len();
        fill_random();
        run_block(8'd0, 16'hFFFF, 8'h01, 0);
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            fill_random();
            run_block(8'($urandom_range(DMAX)), 16'($urandom), 8'($urandom), 60);
        end
    endtask

    task automatic test_len_err();
        fill_random();
        run_block(8'd200, 16'h0100, 8'h00, 0);
        fill_random();
        run_block(8'd65, 16'h0200, 8'h00, 20);
        fill_random();
        run_block(8'd64, 16'h0300, 8'h00, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            fill_random();
            run_block(8'($urandom_range(DMAX)), 16'($urandom), 8'($urandom), $urandom_range(40));
        end
    endtask

    task automatic test_mid_reset();
        fill_random();
        @(posedge clk); #1;
        block_length = 8'd8; block_address = 16'hBEEF; block_type = 8'h00;
        for (int i = 0; i < DMAX; i++) block_data[8*i +: 8] = dat[i];
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (out_data !== dat[3]) begin errors++; $display("FAIL pre_reset_byte: got %h expected %h", out_data, dat[3]); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 0 || prog_addr !== 10'd0 || ready !== 0 || out_data !== 8'h00 || prog_addr8 !== 3'd0) begin
            errors++; $display("FAIL mid_reset: got v=%b a=%0d r=%b data=%h expected 0 0 0 00", out_valid, prog_addr, ready, out_data);
        end
        exp_addr = 0; exp_addr8 = 0; exp_ovf = 0; exp_ovf8 = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        fill_random();
        run_block(8'd5, 16'h4321, 8'h02, 0);
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_addr = 0; exp_addr8 = 0; exp_ovf = 0; exp_ovf8 = 0;
        for (int k = 0; k < 3; k++) begin
            fill_random();
            run_block(8'd2, 16'($urandom), 8'($urandom), 0);
        end
    endtask

    task automatic test_loopback();
        for (int k = 0; k < 4; k++) begin
            int base, l;
            logic [7:0] len, typ;
            logic [15:0] addr;
            fill_random();
            base = exp_addr;
            len = 8'($urandom_range(DMAX));
            addr = 16'($urandom); typ = 8'($urandom);
            run_block(len, addr, typ, 30);
            l = int'(ram[base % SZ]);
            checks++;
            if (l != int'(len) || {ram[(base + 1) % SZ], ram[(base + 2) % SZ]} !== addr || ram[(base + 3) % SZ] !== typ) begin
                errors++; $display("FAIL loopback_hdr: got len=%0d addr=%h type=%h expected %0d %h %h",
                    l, {ram[(base + 1) % SZ], ram[(base + 2) % SZ]}, ram[(base + 3) % SZ], len, addr, typ);
            end
            for (int i = 0; i < l && i < DMAX; i++) begin
                checks++;
                if (ram[(base + 4 + i) % SZ] !== dat[i]) begin
                    errors++; $display("FAIL loopback_data[%0d]: got %h expected %h", i, ram[(base + 4 + i) % SZ], dat[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_stall();
        test_len_err();
        test_random();
        test_mid_reset();
        test_wrap();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
